// File: rtl/mic_pkg.sv
// Shared constants and types for the mic-subsystem correlation back end.
//   DATA_W / LAG_W / MAX_LAG : default widths and lag range
//   NUM_LAGS                 : correlation results per frame (2*MAX_LAG+1)
//   DATA_MIN                 : most negative DATA_W value, the running-max seed
//   xcorr_state_e            : peak-detector state encoding
//   idx_width()              : index counter width for a given frame length
package mic_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LAG_W    = 6;
  localparam int unsigned MAX_LAG  = 31;
  localparam int unsigned NUM_LAGS = 2 * MAX_LAG + 1;

  localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } xcorr_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_track.sv
// Signed running-maximum register with index capture.
//   clk, rst  : clock, synchronous active-high reset (clears to zero)
//   clr       : seed the running max with the most negative value, index 0
//   en        : offer data/idx as a candidate this cycle
//   data, idx : candidate value and its index
//   next_max  : running max including the current candidate (combinational)
//   next_idx  : index of next_max (combinational)
// Only a strictly greater candidate replaces the stored one, so ties keep the
// earliest index.
module argmax_track #(
  parameter int unsigned DATA_W = mic_pkg::DATA_W,
  parameter int unsigned IDX_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] data,
  input  logic        [IDX_W-1:0]  idx,
  output logic signed [DATA_W-1:0] next_max,
  output logic        [IDX_W-1:0]  next_idx
);
  import mic_pkg::*;

  localparam logic signed [DATA_W-1:0] ClrVal = {1'b1, {(DATA_W - 1){1'b0}}};

  logic signed [DATA_W-1:0] max_q;
  logic        [IDX_W-1:0]  idx_q;
  logic                     take;

  always_comb begin
    take     = en && (data > max_q);
    next_max = take ? data : max_q;
    next_idx = take ? idx : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (clr) begin
      max_q <= ClrVal;
      idx_q <= '0;
    end else begin
      max_q <= next_max;
      idx_q <= next_idx;
    end
  end

endmodule

// File: rtl/xcorr_peak_detect.sv
// Peak picker for the serial cross-correlation result stream.
//   clk, rst    : 60 MHz processing clock, synchronous active-high reset
//   frame_start : pulse arming a new frame (aborts a frame in progress)
//   res_valid   : correlation result strobe
//   res_data    : signed correlation result for the next lag
//   threshold   : signed acceptance level, quasi-static
//   lag_diff    : signed lag of the last accepted peak
//   peak_val    : peak value of the last completed frame
//   lag_valid   : one-cycle pulse when a frame completes
//   peak_ok     : with lag_valid, peak exceeded threshold and lag_diff updated
//   busy        : frame being accumulated
//   frame_err   : one-cycle pulse on abort or stray result
// Results for the final lag are folded in combinationally, so all outputs are
// registered on the edge that accepts the last result.
module xcorr_peak_detect #(
  parameter int unsigned DATA_W  = mic_pkg::DATA_W,
  parameter int unsigned LAG_W   = mic_pkg::LAG_W,
  parameter int unsigned MAX_LAG = mic_pkg::MAX_LAG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     res_valid,
  input  logic signed [DATA_W-1:0] res_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic signed [LAG_W-1:0]  lag_diff,
  output logic signed [DATA_W-1:0] peak_val,
  output logic                     lag_valid,
  output logic                     peak_ok,
  output logic                     busy,
  output logic                     frame_err
);
  import mic_pkg::*;

  localparam int unsigned NumLags = 2 * MAX_LAG + 1;
  localparam int unsigned IdxW    = idx_width(NumLags);
  localparam logic [IdxW-1:0]        LastIdx = IdxW'(NumLags - 1);
  localparam logic signed [LAG_W:0]  MaxLagS = (LAG_W + 1)'(MAX_LAG);

  xcorr_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic signed [LAG_W-1:0]  lag_diff_q;
  logic signed [DATA_W-1:0] peak_val_q;
  logic                     lag_valid_q;
  logic                     peak_ok_q;
  logic                     frame_err_q;

  logic                     accept;
  logic                     last;
  logic                     err_d;
  logic                     peak_ok_d;
  logic signed [DATA_W-1:0] next_max;
  logic        [IdxW-1:0]   next_idx;
  logic signed [LAG_W:0]    lag_ext;
  logic                     lag_msb_unused;

  argmax_track #(
    .DATA_W (DATA_W),
    .IDX_W  (IdxW)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .clr      (frame_start),
    .en       (accept),
    .data     (res_data),
    .idx      (idx_q),
    .next_max (next_max),
    .next_idx (next_idx)
  );

  // Widened by one bit so idx - MAX_LAG cannot wrap before truncation.
  assign lag_ext        = $signed((LAG_W + 1)'(next_idx)) - MaxLagS;
  assign lag_msb_unused = lag_ext[LAG_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    // A restart wins over a coincident sample, which is dropped.
    accept    = (state_q == StAccum) && res_valid && !frame_start;
    last      = accept && (idx_q == LastIdx);
    err_d     = (res_valid && (state_q != StAccum)) || (frame_start && (state_q == StAccum));
    peak_ok_d = last && (next_max > threshold);

    unique case (state_q)
      StIdle:  if (frame_start) state_d = StAccum;
      StAccum: begin
        if (frame_start) state_d = StAccum;
        else if (last)   state_d = StDone;
      end
      StDone:  state_d = frame_start ? StAccum : StIdle;
      default: state_d = StIdle;
    endcase

    if (frame_start) idx_d = '0;
    else if (accept) idx_d = last ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      lag_diff_q  <= '0;
      peak_val_q  <= '0;
      lag_valid_q <= 1'b0;
      peak_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lag_valid_q <= last;
      peak_ok_q   <= peak_ok_d;
      frame_err_q <= err_d;
      if (last)      peak_val_q <= next_max;
      if (peak_ok_d) lag_diff_q <= lag_ext[LAG_W-1:0];
    end
  end

  assign lag_diff  = lag_diff_q;
  assign peak_val  = peak_val_q;
  assign lag_valid = lag_valid_q;
  assign peak_ok   = peak_ok_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == StAccum);

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Self-checking bench for xcorr_peak_detect: directed scenarios plus random
// frames compared against a plain array argmax reference model.
module tb_xcorr_peak_detect;

  localparam int NL = 63;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic               res_valid = 1'b0;
  logic signed [31:0] res_data = '0;
  logic signed [31:0] threshold = '0;
  logic signed [5:0]  lag_diff;
  logic signed [31:0] peak_val;
  logic               lag_valid;
  logic               peak_ok;
  logic               busy;
  logic               frame_err;

  int n_vec = 0;
  int n_err = 0;
  int lv_cnt = 0;
  int fe_cnt = 0;
  int m_lag = 0;
  int m_peak = 0;
  int fv [NL];

  xcorr_peak_detect dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .threshold   (threshold),
    .lag_diff    (lag_diff),
    .peak_val    (peak_val),
    .lag_valid   (lag_valid),
    .peak_ok     (peak_ok),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Counts pulses present during the cycle that ends at this edge.
  always @(posedge clk) begin
    if (lag_valid === 1'b1) lv_cnt <= lv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NL; i++) fv[i] = v;
  endtask

  // Streams fv[] as one frame and checks the DONE-cycle outputs.
  task automatic run_frame(input string tag, input int gap_max, input bit do_start,
                           input bit start_after);
    int best;
    bit ok;
    if (do_start) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    for (int i = 0; i < NL; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          res_valid = 1'b0;
          step();
        end
      end
      res_valid = 1'b1;
      res_data  = fv[i];
      step();
    end
    res_valid   = 1'b0;
    frame_start = start_after;
    best = 0;
    for (int i = 1; i < NL; i++) if (fv[i] > fv[best]) best = i;
    ok     = fv[best] > int'(threshold);
    m_peak = fv[best];
    if (ok) m_lag = best - 31;
    n_vec += 5;
    if (lag_valid !== 1'b1) begin
      n_err++; $display("FAIL %s lag_valid got %b want 1", tag, lag_valid);
    end
    if (peak_ok !== ok) begin
      n_err++; $display("FAIL %s peak_ok got %b want %b", tag, peak_ok, ok);
    end
    if (lag_diff !== 6'(m_lag)) begin
      n_err++; $display("FAIL %s lag_diff got %0d want %0d", tag, lag_diff, m_lag);
    end
    if (peak_val !== 32'(m_peak)) begin
      n_err++; $display("FAIL %s peak_val got %0d want %0d", tag, peak_val, m_peak);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s busy_done got %b want 0", tag, busy);
    end
    if (start_after) begin
      step();
      frame_start = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || lag_valid !== 1'b0) begin
        n_err++; $display("FAIL %s restart busy/lag_valid got %b/%b want 1/0", tag, busy, lag_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({lag_diff, peak_val, lag_valid, peak_ok, busy, frame_err} !== '0) begin
      n_err++;
      $display("FAIL reset outputs got lag=%0d peak=%0d lv=%b ok=%b busy=%b err=%b want all 0",
               lag_diff, peak_val, lag_valid, peak_ok, busy, frame_err);
    end
    rst = 1'b0;
    step();
    m_lag = 0;
    m_peak = 0;
  endtask

  task automatic test_single_peak();
    threshold = 0;
    fill(-5);
    fv[40] = 1000;
    run_frame("single_peak", 0, 1'b1, 1'b0);
    step();
    n_vec++;
    if (lag_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_peak_after lv/busy got %b/%b want 0/0", lag_valid, busy);
    end
  endtask

  task automatic test_tie_bounds();
    threshold = 0;
    fill(0);
    fv[0] = 7;
    fv[62] = 7;
    run_frame("tie_first", 2, 1'b1, 1'b0);
    step();
    fill(-1);
    fv[62] = 7;
    run_frame("last_idx", 0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_threshold_reject();
    threshold = 0;
    fill(-5);
    fv[40] = 1000;
    run_frame("prep_plus9", 0, 1'b1, 1'b0);
    step();
    threshold = 100;
    fill(0);
    fv[31] = 50;
    run_frame("reject", 1, 1'b1, 1'b0);
    n_vec++;
    if (lag_diff !== 6'sd9) begin
      n_err++; $display("FAIL reject_hold lag_diff got %0d want 9", lag_diff);
    end
    step();
    threshold = 0;
  endtask

  task automatic test_abort();
    int lv0;
    int fe0;
    lv0 = lv_cnt;
    fe0 = fe_cnt;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      res_valid = 1'b1;
      res_data  = 5000;
      step();
    end
    // Restart coincident with a sample: the sample must be discarded.
    frame_start = 1'b1;
    res_data    = 9999;
    step();
    frame_start = 1'b0;
    res_valid   = 1'b0;
    n_vec++;
    if (frame_err !== 1'b1) begin
      n_err++; $display("FAIL abort_err got %b want 1", frame_err);
    end
    fill(3);
    fv[10] = 400;
    run_frame("abort_frame", 0, 1'b0, 1'b0);
    step();
    step();
    n_vec += 2;
    if (lv_cnt - lv0 != 1) begin
      n_err++; $display("FAIL abort_lv_count got %0d want 1", lv_cnt - lv0);
    end
    if (fe_cnt - fe0 != 1) begin
      n_err++; $display("FAIL abort_err_count got %0d want 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_stray();
    res_valid = 1'b1;
    res_data  = 32'sh7fff_ffff;
    step();
    res_valid = 1'b0;
    n_vec += 2;
    if (frame_err !== 1'b1 || lag_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_idle err/lv got %b/%b want 1/0", frame_err, lag_valid);
    end
    if (lag_diff !== 6'(m_lag) || peak_val !== 32'(m_peak)) begin
      n_err++; $display("FAIL stray_idle_hold lag/peak got %0d/%0d want %0d/%0d",
                        lag_diff, peak_val, m_lag, m_peak);
    end
    step();
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL stray_idle_pulse got %b want 0", frame_err);
    end
    fill(-100);
    fv[5] = 20;
    run_frame("pre_stray_done", 0, 1'b1, 1'b0);
    res_valid = 1'b1;
    res_data  = 32'sh7fff_ffff;
    step();
    res_valid = 1'b0;
    n_vec += 3;
    if (frame_err !== 1'b1 || lag_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_done err/lv got %b/%b want 1/0", frame_err, lag_valid);
    end
    if (lag_diff !== 6'(m_lag) || peak_val !== 32'(m_peak)) begin
      n_err++; $display("FAIL stray_done_hold lag/peak got %0d/%0d want %0d/%0d",
                        lag_diff, peak_val, m_lag, m_peak);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL stray_done_busy got %b want 0", busy);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    int lv0;
    lv0 = lv_cnt;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      res_valid = 1'b1;
      res_data  = 77;
      step();
    end
    res_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_lag = 0;
    m_peak = 0;
    n_vec += 2;
    if (lag_diff !== 6'sd0 || busy !== 1'b0 || lag_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid lag/busy/lv got %0d/%b/%b want 0/0/0", lag_diff, busy, lag_valid);
    end
    if (peak_val !== 32'sd0) begin
      n_err++; $display("FAIL rst_mid_peak got %0d want 0", peak_val);
    end
    step();
    step();
    n_vec++;
    if (lv_cnt != lv0) begin
      n_err++; $display("FAIL rst_mid_lv_count got %0d want 0", lv_cnt - lv0);
    end
    fill(-9);
    fv[0] = 12;
    run_frame("after_rst", 0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      threshold = int'($urandom_range(0, 40)) - 20;
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 9) == 0) fv[i] = int'($urandom());
        else fv[i] = int'($urandom_range(0, 40)) - 20;
      end
      run_frame("random", 3, 1'b1, 1'b0);
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic test_back_to_back();
    threshold = -1000;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NL; i++) fv[i] = int'($urandom_range(0, 15)) - 8;
      run_frame("back_to_back", 0, (f == 0), (f < 2));
    end
    step();
    threshold = 0;
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie_bounds();
    test_threshold_reject();
    test_abort();
    test_stray();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
